// File: rtl/serial_add_arbiter.sv
// Shares one bit-serial adder between two requesters with round-robin arbitration.
// Latency: rsp_valid rises WIDTH edges after the accept edge; at best one op per WIDTH+2 cycles.
// Backpressure: rsp_ready low in DONE freezes all outputs and holds both req readies low.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,

    output logic             busy
);

    // Counter must be able to hold WIDTH, hence clog2(WIDTH+1).
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Operand shift registers, carry flip-flop, sum collector and bookkeeping.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             id_q;
    logic             last_id;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_shift;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_id) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // One full-adder slice on the current LSBs; the new sum bit enters at the MSB
    // so that after WIDTH shifts bit 0 of the result lands at position 0.
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        sum_ext   = {sum_bit, sum_q};
        sum_shift = sum_ext[WIDTH:1];
        last_bit  = (cnt_q == LAST_BIT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs. Readies are gated by reset_n so nothing
    // looks acceptable while the block is held in reset.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & reset_n;
                req1_ready = grant1 & reset_n;
                accept     = grant0 | grant1;
                if (accept) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture the granted request on accept, then shift one bit per ADD cycle.
    // Nothing changes in DONE, which keeps the response stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_id <= 1'b1;
        end else begin
            if (state == IDLE && accept) begin
                a_q     <= grant1 ? req1_a   : req0_a;
                b_q     <= grant1 ? req1_b   : req0_b;
                carry_q <= grant1 ? req1_cin : req0_cin;
                id_q    <= grant1;
                last_id <= grant1;
                cnt_q   <= '0;
            end else if (state == ADD) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                carry_q <= carry_nxt;
                sum_q   <= sum_shift;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

    // Response fields come straight from the registers; after the last bit the
    // carry flip-flop holds the carry out of bit WIDTH-1.
    always_comb begin
        rsp_id   = id_q;
        rsp_sum  = sum_q;
        rsp_cout = carry_q;
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[6];

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
    endtask

    task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
    endtask

    // Counts edges until rsp_valid, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int n;
        rsp_ready = 1'b1;
        if (v.id) begin
            drive0(1'b0, '0, '0, 1'b0);
            drive1(1'b1, v.a, v.b, v.cin);
        end else begin
            drive1(1'b0, '0, '0, 1'b0);
            drive0(1'b1, v.a, v.b, v.cin);
        end
        #1;
        chk({nm, "_ready"}, v.id ? req1_ready : req0_ready, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({nm, "_busy"}, busy, 32'd1);
        wait_rsp(n);
        chk({nm, "_latency"}, n, W);
        chk({nm, "_sum"}, rsp_sum, v.sum);
        chk({nm, "_cout"}, rsp_cout, v.cout);
        chk({nm, "_id"}, rsp_id, v.id);
        step();
        chk({nm, "_rsp_drop"}, rsp_valid, 32'd0);
    endtask

    initial begin
        int n;
        logic [W-1:0] abort_a[2];
        logic [W-1:0] abort_b[2];

        vecs[0] = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        abort_a[0] = 8'hAA; abort_b[0] = 8'h55;
        abort_a[1] = 8'hFF; abort_b[1] = 8'hFF;

        // Reset with both requesters valid (tie operands already on the bus).
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        drive0(1'b1, 8'h10, 8'h20, 1'b0);
        drive1(1'b1, 8'h0F, 8'h01, 1'b1);
        step();
        step();
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_req1_ready", req1_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_rsp_sum", rsp_sum, 32'd0);
        chk("rst_rsp_cout", rsp_cout, 32'd0);
        chk("rst_rsp_id", rsp_id, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("tie1_req0_ready", req0_ready, 32'd1);
        chk("tie1_req1_ready", req1_ready, 32'd0);

        // Tie: req0 first, req1 held valid but never ready while busy.
        rsp_ready = 1'b1;
        step();
        drive0(1'b0, '0, '0, 1'b0);
        for (int i = 1; i <= W; i++) begin
            chk("tie1_req1_blocked", req1_ready, 32'd0);
            chk("tie1_rsp_timing", rsp_valid, 32'd0);
            step();
        end
        chk("tie1_rsp_valid", rsp_valid, 32'd1);
        chk("tie1_sum", rsp_sum, 32'h30);
        chk("tie1_cout", rsp_cout, 32'd0);
        chk("tie1_id", rsp_id, 32'd0);
        chk("tie1_req1_done", req1_ready, 32'd0);
        drive0(1'b1, 8'h03, 8'h04, 1'b0);
        step();
        chk("tie2_req1_ready", req1_ready, 32'd1);
        chk("tie2_req0_ready", req0_ready, 32'd0);
        step();
        for (int i = 1; i <= W; i++) begin
            chk("tie2_req0_blocked", req0_ready, 32'd0);
            step();
        end
        chk("tie2_rsp_valid", rsp_valid, 32'd1);
        chk("tie2_sum", rsp_sum, 32'h11);
        chk("tie2_cout", rsp_cout, 32'd0);
        chk("tie2_id", rsp_id, 32'd1);
        step();
        chk("tie3_req0_ready", req0_ready, 32'd1);
        chk("tie3_req1_ready", req1_ready, 32'd0);
        step();
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        wait_rsp(n);
        chk("tie3_latency", n, W);
        chk("tie3_sum", rsp_sum, 32'h07);
        chk("tie3_id", rsp_id, 32'd0);
        step();

        // Backpressure: response frozen, no accept while rsp_ready is low.
        rsp_ready = 1'b0;
        drive0(1'b1, 8'h12, 8'h34, 1'b0);
        #1;
        chk("bp_req0_ready", req0_ready, 32'd1);
        step();
        drive1(1'b1, 8'h01, 8'h02, 1'b0);
        wait_rsp(n);
        chk("bp_latency", n, W);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 32'd1);
            chk("bp_sum", rsp_sum, 32'h46);
            chk("bp_cout", rsp_cout, 32'd0);
            chk("bp_id", rsp_id, 32'd0);
            chk("bp_req0_ready", req0_ready, 32'd0);
            chk("bp_req1_ready", req1_ready, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_handshake", rsp_valid, 32'd0);
        chk("bp_next_req1_ready", req1_ready, 32'd1);
        chk("bp_next_req0_ready", req0_ready, 32'd0);
        step();
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        chk("bp_next_busy", busy, 32'd1);
        wait_rsp(n);
        chk("bp_next_latency", n, W);
        chk("bp_next_sum", rsp_sum, 32'h03);
        chk("bp_next_id", rsp_id, 32'd1);
        step();

        // Table of single operations alternating requesters.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during ADD aborts the operation and leaves no stale carry.
        for (int k = 0; k < 2; k++) begin
            vec_t v;
            rsp_ready = 1'b1;
            drive0(1'b1, abort_a[k], abort_b[k], 1'b0);
            step();
            drive0(1'b0, '0, '0, 1'b0);
            step();
            step();
            step();
            chk("abort_busy_before", busy, 32'd1);
            reset_n = 1'b0;
            #1;
            chk("abort_rsp_valid", rsp_valid, 32'd0);
            chk("abort_busy", busy, 32'd0);
            chk("abort_sum", rsp_sum, 32'd0);
            chk("abort_cout", rsp_cout, 32'd0);
            step();
            step();
            chk("abort_hold_rsp_valid", rsp_valid, 32'd0);
            reset_n = 1'b1;
            step();
            chk("abort_after_rsp_valid", rsp_valid, 32'd0);
            v = '{1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
            run_op(v, $sformatf("post_abort%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Two-requester scheduler that shares one bit-serial Mealy adder (a single carry flip-flop) between two clients. It arbitrates round-robin between requests and sequences the selected operand pair LSB-first through the adder, one bit per clock. It collects the sum into a result register and returns it with carry-out and the requester ID over a valid/ready response port. It sits between the operand producers and the downstream consumer, so the serial adder never needs a per-client copy.

## Interface
- WIDTH, 8, operand/sum width in bits (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 accepted this cycle (valid&ready at edge = accept)
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result (valid&ready at edge = handshake)
- rsp_id  out  1  requester that owns the result (0/1)
- rsp_sum  out  WIDTH  (a + b + cin) mod 2^WIDTH
- rsp_cout  out  1  carry out of bit WIDTH-1
- busy  out  1  high in ADD and DONE

## Operation
- States: IDLE, ADD, DONE. The reset state is IDLE.
- IDLE, arbitration:
  - If only one reqX_valid is high, that requester is granted.
  - If both are high, the requester not served last is granted. last_id resets to 1, so req0 wins the first tie.
  - reqX_ready = (state==IDLE) & grantX, combinational. At most one ready is high, and it is never high for a requester with valid low.
- Accept edge:
  - Latch a, b, and cin into the carry flip-flop.
  - Latch the ID and set last_id = ID.
  - Clear the bit counter and go to ADD.
- ADD, one bit per cycle:
  - s = a[0]^b[0]^c.
  - c ← (a[0]&b[0]) | (c&(a[0]^b[0])).
  - a, b shift right by 1. The sum register shifts right with s inserted at the MSB.
  - The counter increments. On the edge that processes bit WIDTH-1, go to DONE.
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are held stable until the handshake.
  - On rsp_valid&rsp_ready, go to IDLE.
  - No new request is accepted in the handshake cycle, because ready is only high in IDLE.
- Request inputs are sampled only at the accept edge. Changes afterwards are ignored.
- Counter width is clog2(WIDTH+1). WIDTH=1 is legal: ADD lasts exactly 1 cycle.

## Timing
- Reset values:
  - state=IDLE, last_id=1, carry=0, counter=0, operand and sum regs=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
  - req0_ready=req1_ready=0 while reset_n=0.
- Latency: rsp_valid rises WIDTH edges after the accept edge. busy rises on the accept edge.
- Throughput: a minimum of WIDTH+2 cycles per operation (1 IDLE accept cycle, WIDTH ADD cycles, ≥1 DONE cycle). Back-to-back requests from either client reach this rate when rsp_ready is held high.
- Backpressure: while rsp_ready=0 in DONE, every output is frozen, both readies are 0, and there is no accept.
- Reset asserted mid-ADD or mid-DONE: the operation is aborted immediately and no response is issued. After release, the block is in IDLE with last_id=1.
- Simultaneous events:
  - A requester dropping valid in the same cycle it would be granted is simply not accepted.
  - A valid that arrives while the block is busy waits until IDLE.

## Test plan
- **Reset:** hold reset_n=0 with both valids high → all outputs 0, both readies 0. Release → req0_ready=1 in the first cycle.
- **Single add:** req0 a=0x5A, b=0x33, cin=0 (WIDTH=8) → accept, then rsp_valid exactly 8 edges later with rsp_sum=0x8D, rsp_cout=0, rsp_id=0.
- **Carry/overflow:**
  - req1 0xFF+0x01, cin=0 → rsp_sum=0x00, rsp_cout=1, rsp_id=1.
  - 0xFF+0xFF, cin=1 → rsp_sum=0xFF, rsp_cout=1.
- **Tie arbitration:** both valid from reset, with req0 0x10+0x20 cin=0 and req1 0x0F+0x01 cin=1:
  - req0 is served first (0x30, id 0), and req1_ready stays 0 throughout.
  - req1 is served next (0x11, id 1). The next tie then goes to req0.
- **Backpressure:** rsp_ready=0 for 5 cycles in DONE → rsp_* are stable, both readies are 0 while req valids are high. rsp_ready=1 → handshake, and the next accept happens one cycle later.
- **Reset mid-operation:** assert reset_n=0 after 3 ADD cycles of 0xAA+0x55 → no response, outputs 0. A subsequent 0x01+0x01 cin=0 → 0x02, cout 0, so no stale carry remains.
